pipe_ctrl_stage: RTL and testbench
==================================

# pipe_ctrl_stage

Registered control stage for the 5-stage RISC-V pipeline: decodes the ID-stage opcode into the datapath control bundle and holds it in the ID/EX control register, with stall/flush bubble insertion. Adds an optional M-extension ALU class and a halt-drain state machine that stops fetch and lets older instructions retire before asserting `halted`. Sits between the IF/ID register and the EX stage, driven by the hazard unit (`stall`) and branch unit (`flush`).

## Interface
- `ENABLE_M`, 0: 1 enables `ex_ALU_op = 2'b11` for OP with funct7 = 7'b0000001; 0 decodes these as plain OP.
- `DRAIN_CYCLES`, 3: cycles spent in DRAIN after a halt is accepted; legal range 1..15.
- `HALT_OPCODE`, 7'b1111111: opcode of the halt pseudoinstruction.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  ID-stage opcode.
- `funct7`  in  7  ID-stage funct7, used only when `ENABLE_M = 1`.
- `id_valid`  in  1  ID stage holds a real instruction.
- `stall`  in  1  hazard unit: hold ID, insert bubble into EX.
- `flush`  in  1  branch unit: squash the ID instruction.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_ALU_src`  out  1  0 = register, 1 = immediate.
- `ex_wb_data_src`  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1 each.
- `ex_ALU_op`  out  2  00 = load/store/JALR/LUI/JAL, 01 = branch, 10 = integer computational, 11 = M-extension.
- `ex_ctrl_transfer`  out  2  00 = none, 01 = branch, 10 = JAL, 11 = JALR.
- `fetch_enable`  out  1  PC/IF may advance.
- `halted`  out  1  pipeline stopped; sticky until reset.

## Operation
- Decode, for each opcode:
  - LOAD: ALU_src = 1, wb = 01, reg_write = 1, mem_read = 1.
  - STORE: ALU_src = 1, mem_write = 1.
  - OP: reg_write = 1, ALU_op = 10, or 11 under the M rule.
  - OP_IMM: ALU_src = 1, reg_write = 1, ALU_op = 10.
  - LUI: ALU_src = 1, reg_write = 1.
  - BRANCH: ALU_op = 01, ctrl = 01.
  - JAL: wb = 10, reg_write = 1, ctrl = 10.
  - JALR: ALU_src = 1, wb = 10, reg_write = 1, ctrl = 11.
  - Any other opcode: all controls 0.
- Launch condition: `id_valid & !stall & !flush & state==RUN & opcode!=HALT_OPCODE`.
  - When the launch condition holds, the decoded bundle is loaded into EX with `ex_valid = 1`.
  - Otherwise a bubble is loaded: `ex_valid = 0` and every `ex_*` control is 0.
- A bubble never produces a nonzero `ex_reg_write`, `ex_mem_write` or `ex_ctrl_transfer`.
- FSM states: RUN, DRAIN, HALTED. 4-bit down-counter `drain_cnt`.
  - RUN → DRAIN when `id_valid & !stall & !flush` and opcode = HALT_OPCODE. Load `drain_cnt = DRAIN_CYCLES`. The halt itself enters EX as a bubble.
  - RUN with halt in ID and `stall = 1`: no transition; the halt is accepted on the first unstalled cycle.
  - DRAIN: `id_valid` is ignored (bubbles only) and `drain_cnt` decrements each cycle.
  - DRAIN with `flush = 1`: abort to RUN and clear `drain_cnt`. An older taken branch cancels the halt; flush has priority over decrement.
  - DRAIN → HALTED when `drain_cnt == 1` and `flush = 0`.
  - HALTED: absorbing; bubbles only. Exited only by reset.
- Simultaneous halt-in-ID and `flush`: flush wins; the halt is squashed and the FSM stays in RUN.

## Timing
- Decode-to-EX latency: 1 cycle. Bundle presented in cycle N appears on `ex_*` after edge N+1.
- `fetch_enable` is registered: `fetch_enable = (state == RUN)`.
- Halt accepted at edge N:
  - `fetch_enable = 0` from N+1.
  - `halted = 1` from N+1+DRAIN_CYCLES.
- Reset values: state = RUN, `drain_cnt = 0`, `ex_valid = 0`, all `ex_*` = 0, `fetch_enable = 1`, `halted = 0`.
- Reset asserted mid-DRAIN or in HALTED returns to these values at the next edge.
- `stall` and `flush` are sampled only at the clock edge; they have no combinational path to the `ex_*` outputs.

## Test plan
- Reset then LOAD (0000011) with id_valid: one cycle later `ex_valid = 1`, ALU_src = 1, wb = 01, reg_write = 1, mem_read = 1, ALU_op = 00, ctrl = 00.
- OP with funct7 = 0000001: ENABLE_M = 1 gives ALU_op = 11; ENABLE_M = 0 gives ALU_op = 10.
- JALR with `stall = 1`: EX shows a bubble (all zero, `ex_valid = 0`). Drop stall: next cycle wb = 10, ctrl = 11, reg_write = 1.
- HALT accepted at cycle 10 with DRAIN_CYCLES = 3: `fetch_enable = 0` from cycle 11, `halted = 1` from cycle 14. A JAL in ID during DRAIN yields a bubble.
- HALT accepted, then `flush = 1` in the first DRAIN cycle: FSM returns to RUN, `fetch_enable = 1` next cycle, `halted` never asserts.
- HALT in ID with `flush = 1` the same cycle: stays in RUN. Reset asserted while HALTED: `halted = 0`, `fetch_enable = 1` after the edge.

Source files
------------

// File: rtl/pipe_ctrl_stage.sv
// ID/EX control register for the 5-stage RISC-V pipeline: opcode decode, bubble
// insertion on stall/flush, and a halt-drain FSM that stops fetch before asserting halted.
module pipe_ctrl_stage #(
  parameter bit          ENABLE_M     = 1'b0,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [6:0]  HALT_OPCODE  = 7'b1111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       id_valid,
  input  logic       stall,
  input  logic       flush,
  output logic       ex_valid,
  output logic       ex_ALU_src,
  output logic [1:0] ex_wb_data_src,
  output logic       ex_reg_write,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic [1:0] ex_ALU_op,
  output logic [1:0] ex_ctrl_transfer,
  output logic       fetch_enable,
  output logic       halted
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t     state, state_next;
  logic [3:0] drain_cnt, drain_cnt_next;

  logic       dec_ALU_src;
  logic [1:0] dec_wb_data_src;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic [1:0] dec_ALU_op;
  logic [1:0] dec_ctrl_transfer;

  logic is_halt, accept, launch;

  // ---- ID stage: combinational decode ----
  always_comb begin
    dec_ALU_src       = 1'b0;
    dec_wb_data_src   = 2'b00;
    dec_reg_write     = 1'b0;
    dec_mem_read      = 1'b0;
    dec_mem_write     = 1'b0;
    dec_ALU_op        = 2'b00;
    dec_ctrl_transfer = 2'b00;
    case (opcode)
      OPC_LOAD: begin
        dec_ALU_src     = 1'b1;
        dec_wb_data_src = 2'b01;
        dec_reg_write   = 1'b1;
        dec_mem_read    = 1'b1;
      end
      OPC_STORE: begin
        dec_ALU_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OPC_OP: begin
        dec_reg_write = 1'b1;
        dec_ALU_op    = (ENABLE_M && funct7 == 7'b0000001) ? 2'b11 : 2'b10;
      end
      OPC_OP_IMM: begin
        dec_ALU_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_ALU_op    = 2'b10;
      end
      OPC_LUI: begin
        dec_ALU_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ALU_op        = 2'b01;
        dec_ctrl_transfer = 2'b01;
      end
      OPC_JAL: begin
        dec_wb_data_src   = 2'b10;
        dec_reg_write     = 1'b1;
        dec_ctrl_transfer = 2'b10;
      end
      OPC_JALR: begin
        dec_ALU_src       = 1'b1;
        dec_wb_data_src   = 2'b10;
        dec_reg_write     = 1'b1;
        dec_ctrl_transfer = 2'b11;
      end
      default: ;
    endcase
  end

  assign is_halt = (opcode == HALT_OPCODE);
  assign accept  = id_valid & ~stall & ~flush;
  assign launch  = accept & (state == RUN) & ~is_halt;

  // Halt drain: flush aborts back to RUN ahead of any decrement.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      RUN: begin
        if (accept && is_halt) begin
          state_next     = DRAIN;
          drain_cnt_next = 4'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (flush) begin
          state_next     = RUN;
          drain_cnt_next = 4'd0;
        end else begin
          drain_cnt_next = drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) state_next = HALTED;
        end
      end
      HALTED: state_next = HALTED;
      default: begin
        state_next     = RUN;
        drain_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // ---- ID/EX boundary: control register, bubble unless launching ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_ALU_src       <= 1'b0;
      ex_wb_data_src   <= 2'b00;
      ex_reg_write     <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_ALU_op        <= 2'b00;
      ex_ctrl_transfer <= 2'b00;
      fetch_enable     <= 1'b1;
      halted           <= 1'b0;
    end else begin
      ex_valid         <= launch;
      ex_ALU_src       <= launch & dec_ALU_src;
      ex_wb_data_src   <= launch ? dec_wb_data_src : 2'b00;
      ex_reg_write     <= launch & dec_reg_write;
      ex_mem_read      <= launch & dec_mem_read;
      ex_mem_write     <= launch & dec_mem_write;
      ex_ALU_op        <= launch ? dec_ALU_op : 2'b00;
      ex_ctrl_transfer <= launch ? dec_ctrl_transfer : 2'b00;
      fetch_enable     <= (state == RUN);
      halted           <= halted | (state == HALTED);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed bench for pipe_ctrl_stage: decode bundles, bubbles, M-extension option,
// halt drain, flush abort and reset recovery.
module tb_pipe_ctrl_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       id_valid, stall, flush;

  logic       ex_valid, ex_ALU_src, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0] ex_wb_data_src, ex_ALU_op, ex_ctrl_transfer;
  logic       fetch_enable, halted;

  logic       n_valid, n_ALU_src, n_reg_write, n_mem_read, n_mem_write;
  logic [1:0] n_wb_data_src, n_ALU_op, n_ctrl_transfer;
  logic       n_fetch_enable, n_halted;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_ctrl_stage #(.ENABLE_M(1'b1), .DRAIN_CYCLES(3), .HALT_OPCODE(7'b1111111)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7),
    .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_ALU_src(ex_ALU_src), .ex_wb_data_src(ex_wb_data_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_ALU_op(ex_ALU_op), .ex_ctrl_transfer(ex_ctrl_transfer),
    .fetch_enable(fetch_enable), .halted(halted)
  );

  pipe_ctrl_stage #(.ENABLE_M(1'b0), .DRAIN_CYCLES(3), .HALT_OPCODE(7'b1111111)) dut_nom (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7),
    .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_valid(n_valid), .ex_ALU_src(n_ALU_src), .ex_wb_data_src(n_wb_data_src),
    .ex_reg_write(n_reg_write), .ex_mem_read(n_mem_read), .ex_mem_write(n_mem_write),
    .ex_ALU_op(n_ALU_op), .ex_ctrl_transfer(n_ctrl_transfer),
    .fetch_enable(n_fetch_enable), .halted(n_halted)
  );

  // {valid, ALU_src, wb[1:0], reg_write, mem_read, mem_write, ALU_op[1:0], ctrl[1:0]}
  wire [10:0] ex_bus = {ex_valid, ex_ALU_src, ex_wb_data_src, ex_reg_write, ex_mem_read,
                        ex_mem_write, ex_ALU_op, ex_ctrl_transfer};
  wire [10:0] n_bus  = {n_valid, n_ALU_src, n_wb_data_src, n_reg_write, n_mem_read,
                        n_mem_write, n_ALU_op, n_ctrl_transfer};

  localparam logic [10:0] B_BUBBLE = 11'b0_0_00_0_0_0_00_00;
  localparam logic [10:0] B_LOAD   = 11'b1_1_01_1_1_0_00_00;
  localparam logic [10:0] B_STORE  = 11'b1_1_00_0_0_1_00_00;
  localparam logic [10:0] B_OP     = 11'b1_0_00_1_0_0_10_00;
  localparam logic [10:0] B_OP_M   = 11'b1_0_00_1_0_0_11_00;
  localparam logic [10:0] B_OPIMM  = 11'b1_1_00_1_0_0_10_00;
  localparam logic [10:0] B_LUI    = 11'b1_1_00_1_0_0_00_00;
  localparam logic [10:0] B_BRANCH = 11'b1_0_00_0_0_0_01_01;
  localparam logic [10:0] B_JAL    = 11'b1_0_10_1_0_0_00_10;
  localparam logic [10:0] B_JALR   = 11'b1_1_10_1_0_0_00_11;
  localparam logic [10:0] B_UNK    = 11'b1_0_00_0_0_0_00_00;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011,
                         OPIMM = 7'b0010011, LUI = 7'b0110111, BRANCH = 7'b1100011,
                         JAL = 7'b1101111, JALR = 7'b1100111, HALT = 7'b1111111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] opc);
    opcode = opc; id_valid = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; funct7 = 7'd0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    step();
    check("reset_ex", ex_bus, B_BUBBLE);
    check("reset_fetch", 11'(fetch_enable), 11'd1);
    check("reset_halted", 11'(halted), 11'd0);
    reset = 1'b0;

    issue(LOAD);    check("load", ex_bus, B_LOAD);
    funct7 = 7'b0000001;
    issue(OP);      check("op_m_en", ex_bus, B_OP_M);
                    check("op_m_dis", n_bus, B_OP);
    funct7 = 7'b0000000;
    issue(OP);      check("op_plain", ex_bus, B_OP);
    issue(STORE);   check("store", ex_bus, B_STORE);
    issue(OPIMM);   check("op_imm", ex_bus, B_OPIMM);
    issue(LUI);     check("lui", ex_bus, B_LUI);
    issue(BRANCH);  check("branch", ex_bus, B_BRANCH);
    issue(JAL);     check("jal", ex_bus, B_JAL);
    issue(7'b1010101); check("unknown_opc", ex_bus, B_UNK);

    stall = 1'b1;
    issue(JALR);    check("jalr_stalled", ex_bus, B_BUBBLE);
    stall = 1'b0;
    issue(JALR);    check("jalr_released", ex_bus, B_JALR);
    flush = 1'b1;
    issue(LOAD);    check("load_flushed", ex_bus, B_BUBBLE);
    flush = 1'b0; id_valid = 1'b0;
    step();         check("load_invalid", ex_bus, B_BUBBLE);

    // Halt held by stall, then accepted and drained
    stall = 1'b1;
    issue(HALT);    check("halt_stalled_ex", ex_bus, B_BUBBLE);
    step();         check("halt_stalled_fetch", 11'(fetch_enable), 11'd1);
    stall = 1'b0;
    issue(HALT);    check("halt_accept_ex", ex_bus, B_BUBBLE);
                    check("halt_accept_fetch", 11'(fetch_enable), 11'd1);
    issue(JAL);     check("drain1_fetch", 11'(fetch_enable), 11'd0);
                    check("drain1_jal_bubble", ex_bus, B_BUBBLE);
                    check("drain1_halted", 11'(halted), 11'd0);
    step();         check("drain2_jal_bubble", ex_bus, B_BUBBLE);
                    check("drain2_halted", 11'(halted), 11'd0);
    step();         check("drain3_halted", 11'(halted), 11'd0);
    step();         check("halted_set", 11'(halted), 11'd1);
                    check("halted_fetch", 11'(fetch_enable), 11'd0);
    step();         check("halted_sticky", 11'(halted), 11'd1);
                    check("halted_bubble", ex_bus, B_BUBBLE);

    reset = 1'b1; id_valid = 1'b0;
    step();         check("rst_halted", 11'(halted), 11'd0);
                    check("rst_fetch", 11'(fetch_enable), 11'd1);
                    check("rst_ex", ex_bus, B_BUBBLE);
    reset = 1'b0;

    // Halt aborted by flush in the first drain cycle
    issue(HALT);
    id_valid = 1'b0; flush = 1'b1;
    step();         check("abort_fetch_low", 11'(fetch_enable), 11'd0);
    flush = 1'b0;
    step();         check("abort_fetch_back", 11'(fetch_enable), 11'd1);
    issue(LOAD);    check("abort_load", ex_bus, B_LOAD);
    id_valid = 1'b0;
    step(); step(); step(); step();
    check("abort_never_halted", 11'(halted), 11'd0);
    check("abort_fetch_stays", 11'(fetch_enable), 11'd1);

    // Halt and flush together: halt squashed
    flush = 1'b1;
    issue(HALT);    check("haltflush_ex", ex_bus, B_BUBBLE);
    flush = 1'b0; id_valid = 1'b0;
    step();         check("haltflush_fetch", 11'(fetch_enable), 11'd1);
    issue(LOAD);    check("haltflush_load", ex_bus, B_LOAD);
    id_valid = 1'b0;
    step(); step(); step();
    check("haltflush_not_halted", 11'(halted), 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
